// File: rtl/mem_responder.sv
// Multicycle memory responder: one request at a time over valid/ready, response strobe
// after LATENCY cycles, word/half/byte accesses with big-endian byte lanes.
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        commit;
    logic        write_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        resp_valid_reg;
    logic        resp_error_reg;
    logic [31:0] resp_rdata_reg;

    assign req_ready = (state_reg == IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    cnt_next = CNT_INIT;
                    if (LATENCY > 1) begin
                        state_next = WAIT;
                    end else begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_reg == IDLE && req_valid && !reset) begin
            write_reg <= req_write;
            size_reg  <= req_size;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end
    end

    // With LATENCY=1 the commit edge is the acceptance edge, so use the live inputs there.
    logic        cur_write;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    assign cur_write = (state_reg == IDLE) ? req_write : write_reg;
    assign cur_size  = (state_reg == IDLE) ? req_size  : size_reg;
    assign cur_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

    logic          err;
    logic [AW-1:0] idx;
    logic [1:0]    offset;
    logic [3:0]    be;
    logic [31:0]   wdata_word;
    logic [31:0]   rd_word;
    logic [31:0]   load_data;
    logic          mem_we;

    assign err = (cur_size == 2'b11)
               || (cur_size == 2'b01 && cur_addr[0])
               || (cur_size == 2'b00 && cur_addr[1:0] != 2'b00)
               || (cur_addr >= ADDR_LIMIT);
    assign idx    = cur_addr[AW+1:2];
    assign offset = cur_addr[1:0];
    assign mem_we = commit && !reset && cur_write && !err;

    // Lane gi holds bits [8*gi+7:8*gi], i.e. byte offset 3-gi (offset 0 is the MSB lane).
    always_comb begin
        be         = 4'b0000;
        wdata_word = {4{cur_wdata[7:0]}};
        load_data  = 32'd0;
        case (cur_size)
            2'b00: begin
                be         = 4'b1111;
                wdata_word = cur_wdata;
                load_data  = rd_word;
            end
            2'b01: begin
                be         = offset[1] ? 4'b0011 : 4'b1100;
                wdata_word = {2{cur_wdata[15:0]}};
                load_data  = {16'd0, 16'(rd_word >> {~offset[1], 4'b0000})};
            end
            2'b10: begin
                be        = 4'b1000 >> offset;
                load_data = {24'd0, 8'(rd_word >> {~offset, 3'b000})};
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            always_ff @(posedge clk) begin
                if (mem_we && be[gi]) begin
                    lane_mem[idx] <= wdata_word[8*gi +: 8];
                end
            end
            // Asynchronous read so a LATENCY=1 load can be answered on its acceptance edge.
            assign rd_word[8*gi +: 8] = lane_mem[idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_reg <= 1'b0;
            resp_error_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
        end else begin
            resp_valid_reg <= commit;
            resp_error_reg <= commit && err;
            if (commit) begin
                resp_rdata_reg <= (cur_write || err) ? 32'd0 : load_data;
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_error = resp_error_reg;
    assign resp_rdata = resp_rdata_reg;
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; LATENCY=2 main instance plus
// LATENCY=1 and LATENCY=5 instances sharing the request inputs for the latency sweep.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready,  resp_valid,  resp_error;
    logic [31:0] resp_rdata;
    logic        req_ready1, resp_valid1, resp_error1;
    logic [31:0] resp_rdata1;
    logic        req_ready5, resp_valid5, resp_error5;
    logic [31:0] resp_rdata5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error));

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_error(resp_error1));

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(5)) u_dut_l5 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready5),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid5), .resp_rdata(resp_rdata5), .resp_error(resp_error5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request to the LATENCY=2 instance; lat=-1 when it never completes.
    task automatic do_req(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] rd,
                          output logic er);
        logic rdy;
        bit   acc;
        lat = -1; rd = 'x; er = 1'bx; acc = 0;
        req_write = w; req_size = s; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rdy = req_ready;
            tick();
            if (rdy) begin acc = 1; break; end
        end
        req_valid = 1'b0;
        if (acc) begin
            for (int k = 0; k < 20; k++) begin
                if (resp_valid) begin
                    lat = k + 1; rd = resp_rdata; er = resp_error;
                    break;
                end
                tick();
            end
        end
        $display("REQ w=%0d size=%0d addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0b",
                 w, s, a, d, lat, rd, er);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_addr = 32'h30; req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: valid=%b rdata=0x%08h ready=%b, want 0/0/0",
                         i, resp_valid, resp_rdata, req_ready);
            end
        end
        reset = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_accept cycle %0d: resp_valid=%b want 0", i, resp_valid);
            end
        end
        $display("TEST reset done");
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL word_store: lat=%0d err=%b rdata=0x%08h want 2/0/0", lat, er, rd);
        end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL word_load: lat=%0d err=%b rdata=0x%08h want 2/0/0xdeadbeef", lat, er, rd);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL strobe_hold: valid=%b rdata=0x%08h want 0/0xdeadbeef", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_subword();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 2'b10, 32'h11, 32'h0000_00AA, lat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b0) begin
            errors++;
            $display("FAIL byte_store: lat=%0d err=%b want 2/0", lat, er);
        end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEAA_BEEF) begin
            errors++;
            $display("FAIL after_byte_store: err=%b rdata=0x%08h want 0/0xdeaabeef", er, rd);
        end
        do_req(1'b0, 2'b01, 32'h12, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL half_load_12: err=%b rdata=0x%08h want 0/0x0000beef", er, rd);
        end
        do_req(1'b0, 2'b01, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0000_DEAA) begin
            errors++;
            $display("FAIL half_load_10: err=%b rdata=0x%08h want 0/0x0000deaa", er, rd);
        end
        do_req(1'b0, 2'b10, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0000_00DE) begin
            errors++;
            $display("FAIL byte_load_10: err=%b rdata=0x%08h want 0/0x000000de", er, rd);
        end
        do_req(1'b0, 2'b10, 32'h13, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0000_00EF) begin
            errors++;
            $display("FAIL byte_load_13: err=%b rdata=0x%08h want 0/0x000000ef", er, rd);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 2'b00, 32'h02, 32'h0, lat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL misaligned_word: lat=%0d err=%b rdata=0x%08h want 2/1/0", lat, er, rd);
        end
        do_req(1'b1, 2'b01, 32'h13, 32'h0000_5555, lat, rd, er);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_half_store: err=%b want 1", er);
        end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEAA_BEEF) begin
            errors++;
            $display("FAIL mem_unchanged: err=%b rdata=0x%08h want 0/0xdeaabeef", er, rd);
        end
        do_req(1'b0, 2'b11, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL reserved_size: err=%b rdata=0x%08h want 1/0", er, rd);
        end
        do_req(1'b0, 2'b00, 32'h100, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL out_of_range: err=%b rdata=0x%08h want 1/0", er, rd);
        end
        do_req(1'b1, 2'b00, 32'hFC, 32'hCAFE_F00D, lat, rd, er);
        do_req(1'b0, 2'b00, 32'hFC, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL last_word: err=%b rdata=0x%08h want 0/0xcafef00d", er, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic        rdy;
        int          acc2 = -1;
        bit          got1 = 0;
        bit          got2 = 0;
        logic [31:0] r1 = 'x;
        logic [31:0] r2 = 'x;
        req_write = 1'b0; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rdy = req_ready;
            tick();
            if (rdy) break;
        end
        // First request now accepted; change the inputs while it is in flight.
        req_size = 2'b01; req_addr = 32'h12;
        for (int i = 1; i <= 10; i++) begin
            rdy = req_ready;
            tick();
            if (rdy) begin acc2 = i; break; end
            if (resp_valid && !got1) begin got1 = 1; r1 = resp_rdata; end
        end
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (resp_valid) begin got2 = 1; r2 = resp_rdata; break; end
            tick();
        end
        $display("B2B second_accept=+%0d r1=0x%08h r2=0x%08h", acc2, r1, r2);
        checks++;
        if (acc2 !== 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d edges want 3", acc2);
        end
        checks++;
        if (!got1 || r1 !== 32'hDEAA_BEEF) begin
            errors++;
            $display("FAIL addr_change_in_wait: got1=%0d rdata=0x%08h want 0xdeaabeef", got1, r1);
        end
        checks++;
        if (!got2 || r2 !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL b2b_second: got2=%0d rdata=0x%08h want 0x0000beef", got2, r2);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er;
        logic rdy;
        bit   seen = 0;
        do_req(1'b1, 2'b00, 32'h20, 32'h1111_1111, lat, rd, er);
        req_write = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rdy = req_ready;
            tick();
            if (rdy) break;
        end
        req_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (resp_valid) seen = 1;
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_no_resp: resp_valid seen=1 want 0");
        end
        do_req(1'b0, 2'b00, 32'h20, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h1111_1111) begin
            errors++;
            $display("FAIL reset_mid_old_value: err=%b rdata=0x%08h want 0/0x11111111", er, rd);
        end
    endtask

    task automatic test_latency_sweep();
        int lat; logic [31:0] rd; logic er;
        int l1 = -1, l2 = -1, l5 = -1;
        logic [31:0] d1 = 'x, d5 = 'x;
        for (int i = 0; i < 8; i++) tick();
        do_req(1'b1, 2'b00, 32'h40, 32'h0BAD_F00D, lat, rd, er);
        for (int i = 0; i < 8; i++) tick();
        req_write = 1'b0; req_size = 2'b00; req_addr = 32'h40; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (resp_valid1 && l1 < 0) begin l1 = k + 1; d1 = resp_rdata1; end
            if (resp_valid  && l2 < 0) l2 = k + 1;
            if (resp_valid5 && l5 < 0) begin l5 = k + 1; d5 = resp_rdata5; end
            tick();
        end
        $display("SWEEP lat1=%0d lat2=%0d lat5=%0d d1=0x%08h d5=0x%08h", l1, l2, l5, d1, d5);
        checks++;
        if (l1 !== 1 || d1 !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL latency1: lat=%0d rdata=0x%08h want 1/0x0badf00d", l1, d1);
        end
        checks++;
        if (l2 !== 2) begin
            errors++;
            $display("FAIL latency2: lat=%0d want 2", l2);
        end
        checks++;
        if (l5 !== 5 || d5 !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL latency5: lat=%0d rdata=0x%08h want 5/0x0badf00d", l5, d5);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_addr = 32'h0; req_wdata = 32'h0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_latency_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
